// File: rtl/hazard_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pipe
//
// Hazard and forwarding controller for the 5-stage pipelined core. Tracks the
// destination tags of in-flight instructions through the E, M and W stages.
// From these tags it produces:
//   - operand forwarding selects for the Execute stage,
//   - load-use stalls,
//   - branch and PC-write flushes,
//   - PC-write-pending stalls.
//
// Parameters:
//   AW      register address width
//   NRP     number of register read ports checked per instruction
//   PC_REG  register index of the PC (never forwarded; writes are PC writes)
//   CW      width of the optional performance counters
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   ra_d, use_d      Decode source addresses (port i at [i*AW +: AW]) / used
//   wa_d             Decode destination register
//   regwrite_d       Decode instruction writes the register file
//   memtoreg_d       Decode instruction is a load
//   branch_taken_e   branch resolved taken in Execute
//   stall_f/stall_d  hold PC / hold F/D register
//   flush_d/flush_e  clear F/D / clear D/E register
//   fwd_e            per-port forward select: 00 regfile, 01 ResultW, 10 ALUOutM
//   stall_cnt        stall-cycle counter (optional)
//   flush_cnt        flush-cycle counter (optional)
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   When defined, the counters are built. They are saturating counters that
//   clear on reset. When undefined, both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module hazard_ctrl_pipe #(
    parameter int AW     = 4,
    parameter int NRP    = 2,
    parameter int PC_REG = 15,
    parameter int CW     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   ra_d,
    input  logic [NRP-1:0]      use_d,
    input  logic [AW-1:0]       wa_d,
    input  logic                regwrite_d,
    input  logic                memtoreg_d,
    input  logic                branch_taken_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_d,
    output logic                flush_e,
    output logic [2*NRP-1:0]    fwd_e,
    output logic [CW-1:0]       stall_cnt,
    output logic [CW-1:0]       flush_cnt
);

    localparam logic [AW-1:0] PC_A = AW'(PC_REG);

    // E-stage tags
    logic [NRP*AW-1:0] ra_e_q,       ra_e_d;
    logic [NRP-1:0]    use_e_q,      use_e_d;
    logic [AW-1:0]     wa_e_q,       wa_e_d;
    logic              regwrite_e_q, regwrite_e_d;
    logic              memtoreg_e_q, memtoreg_e_d;
    logic              pcwrite_e_q,  pcwrite_e_d;

    // M-stage and W-stage tags
    logic [AW-1:0]     wa_m_q, wa_w_q;
    logic              regwrite_m_q, regwrite_w_q;
    logic              memtoreg_m_q, memtoreg_w_q;
    logic              pcwrite_m_q,  pcwrite_w_q;

    logic              pcwrite_d;
    logic              ldr_hit;
    logic              ldrstall;
    logic              pcwr_pend;

    // The load flag is carried to W so that the tag set stays uniform.
    // Nothing downstream of E consumes it.
    logic              unused_memtoreg;
    assign unused_memtoreg = memtoreg_m_q ^ memtoreg_w_q;

    assign pcwrite_d = regwrite_d & (wa_d == PC_A);

    always_comb begin
        fwd_e   = '0;
        ldr_hit = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            // M wins over W: it holds the younger result.
            if (use_e_q[i] && regwrite_m_q && (wa_m_q == ra_e_q[i*AW +: AW]) &&
                (ra_e_q[i*AW +: AW] != PC_A)) begin
                fwd_e[2*i +: 2] = 2'b10;
            end else if (use_e_q[i] && regwrite_w_q && (wa_w_q == ra_e_q[i*AW +: AW]) &&
                         (ra_e_q[i*AW +: AW] != PC_A)) begin
                fwd_e[2*i +: 2] = 2'b01;
            end
            if (use_d[i] && (ra_d[i*AW +: AW] == wa_e_q)) begin
                ldr_hit = 1'b1;
            end
        end
        ldrstall = memtoreg_e_q & regwrite_e_q & ldr_hit;
    end

    assign pcwr_pend = pcwrite_d | pcwrite_e_q | pcwrite_m_q;

    assign stall_f = ldrstall | pcwr_pend;
    assign stall_d = ldrstall;
    assign flush_d = pcwr_pend | pcwrite_w_q | branch_taken_e;
    assign flush_e = ldrstall | branch_taken_e;

    // D->E tags: a flush of D/E inserts a bubble with all tags cleared.
    always_comb begin
        ra_e_d       = ra_d;
        use_e_d      = use_d;
        wa_e_d       = wa_d;
        regwrite_e_d = regwrite_d;
        memtoreg_e_d = memtoreg_d;
        pcwrite_e_d  = pcwrite_d;
        if (flush_e) begin
            ra_e_d       = '0;
            use_e_d      = '0;
            wa_e_d       = '0;
            regwrite_e_d = 1'b0;
            memtoreg_e_d = 1'b0;
            pcwrite_e_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra_e_q       <= '0;
            use_e_q      <= '0;
            wa_e_q       <= '0;
            regwrite_e_q <= 1'b0;
            memtoreg_e_q <= 1'b0;
            pcwrite_e_q  <= 1'b0;
            wa_m_q       <= '0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            pcwrite_m_q  <= 1'b0;
            wa_w_q       <= '0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            pcwrite_w_q  <= 1'b0;
        end else begin
            ra_e_q       <= ra_e_d;
            use_e_q      <= use_e_d;
            wa_e_q       <= wa_e_d;
            regwrite_e_q <= regwrite_e_d;
            memtoreg_e_q <= memtoreg_e_d;
            pcwrite_e_q  <= pcwrite_e_d;
            wa_m_q       <= wa_e_q;
            regwrite_m_q <= regwrite_e_q;
            memtoreg_m_q <= memtoreg_e_q;
            pcwrite_m_q  <= pcwrite_e_q;
            wa_w_q       <= wa_m_q;
            regwrite_w_q <= regwrite_m_q;
            memtoreg_w_q <= memtoreg_m_q;
            pcwrite_w_q  <= pcwrite_m_q;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_d | stall_f) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
        if ((flush_d | flush_e) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_pipe
//
// Directed and random stimulus for hazard_ctrl_pipe. The DUT is checked
// against an instruction-level model. The model holds the instructions
// currently in E, M and W and applies the hazard rules to them directly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_pipe;

    localparam int AW  = 4;
    localparam int NRP = 2;
`ifdef HAZ_PERF_CNT_EN
    localparam int CW  = 4;
`else
    localparam int CW  = 32;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NRP*AW-1:0]   ra_d;
    logic [NRP-1:0]      use_d;
    logic [AW-1:0]       wa_d;
    logic                regwrite_d;
    logic                memtoreg_d;
    logic                branch_taken_e;
    logic                stall_f, stall_d, flush_d, flush_e;
    logic [2*NRP-1:0]    fwd_e;
    logic [CW-1:0]       stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(.AW(AW), .NRP(NRP), .PC_REG(15), .CW(CW)) dut (
        .clk(clk), .reset(reset), .ra_d(ra_d), .use_d(use_d), .wa_d(wa_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
        .branch_taken_e(branch_taken_e), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .fwd_e(fwd_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [7:0] ra;
        logic [1:0] rd_en;
        logic [3:0] wa;
        logic       rw;
        logic       ld;
        logic       pcw;
    } instr_t;

    // pipe[0] = instruction in E, pipe[1] = M, pipe[2] = W
    instr_t        pipe [3];
    logic [CW-1:0] m_scnt, m_fcnt;

    int checks = 0;
    int errors = 0;

    // Snapshot of the DUT outputs taken by the most recent step.
    logic       g_sf, g_sd, g_fd, g_fe;
    logic [3:0] g_fwd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_scnt = '0;
        m_fcnt = '0;
    endtask

    // Produces the forward select for a source register, from the
    // instructions in M and W.
    function automatic logic [1:0] fwd_for(input logic [3:0] src, input logic en);
        if (!en || src == 4'd15) return 2'b00;
        if (pipe[1].rw && pipe[1].wa == src) return 2'b10;
        if (pipe[2].rw && pipe[2].wa == src) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle with the given instruction presented in Decode.
    task automatic step(input logic [7:0] ra, input logic [1:0] ue, input logic [3:0] wa,
                        input logic rw, input logic ld, input logic bt);
        instr_t     d;
        logic       e_ld, e_pend, e_sf, e_sd, e_fd, e_fe;
        logic [3:0] e_fwd;
        logic [3:0] src [2];
        @(negedge clk);
        ra_d = ra; use_d = ue; wa_d = wa;
        regwrite_d = rw; memtoreg_d = ld; branch_taken_e = bt;
        #1;
        d.ra = ra; d.rd_en = ue; d.wa = wa; d.rw = rw; d.ld = ld;
        d.pcw = rw && (wa == 4'd15);
        src[0] = ra[3:0];
        src[1] = ra[7:4];
        e_ld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e_fwd[2*i +: 2] = fwd_for(pipe[0].ra[4*i +: 4], pipe[0].rd_en[i]);
            if (pipe[0].ld && pipe[0].rw && ue[i] && src[i] == pipe[0].wa) e_ld = 1'b1;
        end
        e_pend = d.pcw || pipe[0].pcw || pipe[1].pcw;
        e_sf = e_ld || e_pend;
        e_sd = e_ld;
        e_fd = e_pend || pipe[2].pcw || bt;
        e_fe = e_ld || bt;
        g_sf = stall_f; g_sd = stall_d; g_fd = flush_d; g_fe = flush_e; g_fwd = fwd_e;
        chk("stall_f", 64'(stall_f), 64'(e_sf));
        chk("stall_d", 64'(stall_d), 64'(e_sd));
        chk("flush_d", 64'(flush_d), 64'(e_fd));
        chk("flush_e", 64'(flush_e), 64'(e_fe));
        chk("fwd_e", 64'(fwd_e), 64'(e_fwd));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
        @(posedge clk);
        if (!reset) begin
`ifdef HAZ_PERF_CNT_EN
            if ((e_sf || e_sd) && m_scnt != {CW{1'b1}}) m_scnt = m_scnt + 1'b1;
            if ((e_fd || e_fe) && m_fcnt != {CW{1'b1}}) m_fcnt = m_fcnt + 1'b1;
`endif
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e_fe ? instr_t'('0) : d;
        end
    endtask

    task automatic nop(input int n);
        repeat (n) step(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks that every output drops at once.
    task automatic mid_reset();
        @(negedge clk);
        ra_d = '0; use_d = '0; wa_d = '0;
        regwrite_d = 0; memtoreg_d = 0; branch_taken_e = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_stall_f", 64'(stall_f), 64'd0);
        chk("rst_stall_d", 64'(stall_d), 64'd0);
        chk("rst_flush_d", 64'(flush_d), 64'd0);
        chk("rst_flush_e", 64'(flush_e), 64'd0);
        chk("rst_fwd_e", 64'(fwd_e), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        clear_model();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [3:0] r0, r1;
        logic       lw;

        reset = 1'b1;
        ra_d = '0; use_d = '0; wa_d = '0;
        regwrite_d = 0; memtoreg_d = 0; branch_taken_e = 0;
        clear_model();
        #3;
        chk("init_outputs", 64'({stall_f, stall_d, flush_d, flush_e, fwd_e}), 64'd0);
        chk("init_stall_cnt", 64'(stall_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset arrives while forwarding would otherwise fire
        // (writer of r3 in M, reader of r3 in E).
        step(8'h00, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0);
        step(8'h03, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0);
        mid_reset();
        step(8'h03, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        nop(1);
        chk("post_reset_no_fwd", 64'(g_fwd), 64'd0);

        // ADD r2 immediately followed by a reader of r2 -> ALUOutM
        nop(3);
        step(8'h00, 2'b00, 4'd2, 1'b1, 1'b0, 1'b0);
        step(8'h02, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0);
        nop(1);
        chk("fwd_dist1", 64'(g_fwd[1:0]), 64'h2);
        // one NOP between -> ResultW
        nop(3);
        step(8'h00, 2'b00, 4'd2, 1'b1, 1'b0, 1'b0);
        nop(1);
        step(8'h02, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0);
        nop(1);
        chk("fwd_dist2", 64'(g_fwd[1:0]), 64'h1);
        // two NOPs between -> register file
        nop(3);
        step(8'h00, 2'b00, 4'd2, 1'b1, 1'b0, 1'b0);
        nop(2);
        step(8'h02, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0);
        nop(1);
        chk("fwd_dist3", 64'(g_fwd[1:0]), 64'h0);

        // Load-use on port 1: one stall cycle, then forward from W.
        nop(3);
        step(8'h00, 2'b00, 4'd5, 1'b1, 1'b1, 1'b0);
        step(8'h50, 2'b10, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("ldr_stall", 64'({g_sf, g_sd, g_fe}), 64'h7);
        step(8'h50, 2'b10, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("ldr_one_cycle", 64'({g_sd, g_fe}), 64'h0);
        nop(1);
        chk("ldr_fwd_w", 64'(g_fwd[3:2]), 64'h1);

        // Write to r15: PC-write stalls/flushes, and r15 is never forwarded.
        nop(3);
        step(8'h00, 2'b00, 4'd15, 1'b1, 1'b0, 1'b0);
        chk("pc_d", 64'({g_sf, g_fd}), 64'h3);
        step(8'h0F, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("pc_e", 64'({g_sf, g_fd}), 64'h3);
        nop(1);
        chk("pc_m", 64'({g_sf, g_fd}), 64'h3);
        chk("pc_no_fwd", 64'(g_fwd), 64'h0);
        nop(1);
        chk("pc_w", 64'({g_sf, g_fd}), 64'h1);
        nop(1);
        chk("pc_done", 64'({g_sf, g_fd}), 64'h0);

        // Taken branch coincident with a load-use stall.
        nop(3);
        step(8'h00, 2'b00, 4'd5, 1'b1, 1'b1, 1'b0);
        step(8'h50, 2'b10, 4'd6, 1'b1, 1'b0, 1'b1);
        chk("br_ldr", 64'({g_fd, g_fe, g_sd}), 64'h7);
        step(8'h50, 2'b10, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("br_bubble", 64'(g_fwd), 64'h0);

`ifdef HAZ_PERF_CNT_EN
        mid_reset();
        repeat (20) step(8'h00, 2'b00, 4'd15, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stall_cnt_sat", 64'(stall_cnt), 64'hF);
        mid_reset();
`endif

        // Random traffic on a small register set (r0..r3 and r15),
        // so that hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            r0 = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
            r1 = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
            lw = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                mid_reset();
            end else begin
                step({r1, r0}, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                     lw | ($urandom_range(0, 1) == 1), lw,
                     ($urandom_range(0, 9) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
